mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multi-cycle controller for the RV32M instructions the single-cycle ALU cannot execute in one cycle.
- Handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU through an iterative 32-step shift-add multiply and restoring divide.
- Sits beside the ALU in EX. The decoder raises start when an opcode=0110011, funct7=0000001 instruction enters EX.
- Stalls the front of the pipeline until the result is ready, then presents it on the write-back mux.

Parameters:
- XLEN, 32, operand and result width.
- STEP_CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- flush  input  1  abort current operation (branch mispredict or trap)
- funct3  input  3  M-extension operation select
- ReadData1  input  XLEN  rs1 operand
- ReadData2  input  XLEN  rs2 operand
- MDUResult  output  XLEN  result, registered
- done  output  1  one-cycle pulse when MDUResult is valid
- busy  output  1  state != IDLE
- stall  output  1  combinational: (start & IDLE) | (state not in {IDLE, DONE})

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. On any clk edge with rst_n=0: state=IDLE, MDUResult=0, done=0, busy=0, counter=0, internal registers=0.
- States:
  - IDLE: start=1 latches operands and funct3, then goes to PREP.
  - PREP: 1 cycle. Computes absolute values for signed ops and records result sign. Goes to DONE on the fast path, otherwise to CALC with counter=0.
  - CALC: 32 cycles, one bit per cycle, counter increments. After counter=31, goes to FIX.
  - FIX: 1 cycle. Applies two's-complement negation where the sign requires it and selects the high or low half, or quotient or remainder. Goes to DONE.
  - DONE: 1 cycle. done=1, MDUResult updated. Returns to IDLE.
- Latency: start sampled at cycle T gives done at T+35 on the normal path and at T+2 on the fast path. stall is low in the DONE cycle, so the instruction retires then.
- Multiply:
  - 64-bit product.
  - MUL returns the low 32 bits.
  - MULH: both operands signed; returns high 32 bits.
  - MULHSU: rs1 signed, rs2 unsigned; returns high 32 bits.
  - MULHU: both unsigned; returns high 32 bits.
- Divide: truncates toward zero. Remainder takes the sign of the dividend.
- Fast path, decided in PREP:
  - Divide by zero: quotient=0xFFFFFFFF, remainder=ReadData1.
  - Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0.
- start while busy: ignored. Holding start high in the DONE cycle does not retrigger; only a start seen in IDLE is accepted.
- flush: in any state other than IDLE, the next state is IDLE. No done is produced and MDUResult keeps its old value. flush and start together in IDLE: flush wins, request is not accepted.
- Reset mid-operation: same as reset; no done.
- MDUResult holds its value until the next DONE.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: any multiply whose (post-abs) operand is 0 takes the fast path, giving result 0 and done at T+2. Any multiply whose operand is 1 also takes the fast path; the result is the other operand, sign- or zero-extended per funct3.
- Undefined: all multiplies take 35 cycles; fast path is for division only.

Test Plan:
- MUL 7 × 6, start at T → stall high T..T+34, done at T+35, MDUResult=42; busy low at T+36.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Divide fast paths:
  - DIV −7 / 2 → −3 (0xFFFFFFFD); REM → −1.
  - DIVU 5 / 0 → 0xFFFFFFFF at T+2; REMU 5 / 0 → 5.
  - DIV 0x80000000 / −1 → 0x80000000 at T+2.
- flush at T+10 of a DIVU → IDLE at T+11, no done pulse, MDUResult unchanged.
- rst_n=0 for one cycle at T+20 → all outputs 0 next edge. A new start then completes normally in 35 cycles.
- With MDU_EARLY_OUT_EN: MUL 0 × 1234 → 0, done at T+2. Without it: same operands give done at T+35.

Source files
------------

// File: rtl/mdu_sequencer_if.sv
// Request/response bundle between the EX-stage decoder and the RV32M multi-cycle unit.
// master = pipeline side (drives request), slave = mdu_sequencer (drives result and status).
interface mdu_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] ReadData1;
    logic [XLEN-1:0] ReadData2;
    logic [XLEN-1:0] MDUResult;
    logic            done;
    logic            busy;
    logic            stall;

    // start is only taken in IDLE; done pulses for exactly one cycle and marks MDUResult valid.
    modport master (
        output start, flush, funct3, ReadData1, ReadData2,
        input  MDUResult, done, busy, stall
    );

    modport slave (
        input  start, flush, funct3, ReadData1, ReadData2,
        output MDUResult, done, busy, stall
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply and restoring divide.
// Optional MDU_EARLY_OUT_EN: multiplies by 0 or +/-1 finish on the fast path.
module mdu_sequencer #(
    parameter int XLEN       = 32,
    parameter int STEP_CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mdu_sequencer_if.slave        mdu,
    output logic [2:0]            o_state
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t                r_state;
    state_t                w_next;
    logic [XLEN-1:0]       r_a;
    logic [XLEN-1:0]       r_b;
    logic [XLEN-1:0]       r_hi;
    logic [XLEN-1:0]       r_lo;
    logic [2:0]            r_op;
    logic                  r_neg;
    logic [STEP_CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]       r_result;

    logic                  w_is_div;
    logic                  w_a_signed;
    logic                  w_b_signed;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [XLEN-1:0]       w_a_abs;
    logic [XLEN-1:0]       w_b_abs;
    logic                  w_res_neg;
    logic                  w_div_zero;
    logic                  w_div_ovf;
    logic                  w_fast;
    logic [XLEN-1:0]       w_fast_res;
    logic [XLEN:0]         w_sum;
    logic [XLEN:0]         w_trial;
    logic [XLEN-1:0]       w_fin_hi;
    logic [XLEN-1:0]       w_fin_lo;
    logic                  w_fin_neg;
    logic [2*XLEN-1:0]     w_prod;
    logic [XLEN-1:0]       w_divsel;
    logic [XLEN-1:0]       w_fin;

    // funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
    assign w_is_div   = r_op[2];
    assign w_a_signed = (r_op == 3'b001) || (r_op == 3'b010) || (r_op == 3'b100) || (r_op == 3'b110);
    assign w_b_signed = (r_op == 3'b001) || (r_op == 3'b100) || (r_op == 3'b110);
    assign w_a_neg    = w_a_signed & r_a[XLEN-1];
    assign w_b_neg    = w_b_signed & r_b[XLEN-1];
    assign w_a_abs    = w_a_neg ? (~r_a + 1'b1) : r_a;
    assign w_b_abs    = w_b_neg ? (~r_b + 1'b1) : r_b;
    // Remainder follows the dividend; quotient and product follow the XOR of both signs.
    assign w_res_neg  = (w_is_div && r_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div_zero = w_is_div && (r_b == '0);
    assign w_div_ovf  = w_is_div && !r_op[0] && (r_a == MIN_NEG) && (r_b == '1);

    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_b};

    // The same sign-fix/half-select serves FIX and the early-out multiply in PREP.
    always_comb begin
        w_fin_hi  = r_hi;
        w_fin_lo  = r_lo;
        w_fin_neg = r_neg;
        if (r_state != S_FIX) begin
            w_fin_hi  = '0;
            w_fin_lo  = (w_a_abs == XLEN'(1)) ? w_b_abs : w_a_abs;
            w_fin_neg = w_res_neg;
        end
        w_prod   = w_fin_neg ? (~{w_fin_hi, w_fin_lo} + 1'b1) : {w_fin_hi, w_fin_lo};
        w_divsel = r_op[1] ? w_fin_hi : w_fin_lo;
        if (w_is_div) begin
            w_fin = w_fin_neg ? (~w_divsel + 1'b1) : w_divsel;
        end else if (r_op == 3'b000) begin
            w_fin = w_prod[XLEN-1:0];
        end else begin
            w_fin = w_prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        w_fast     = w_div_zero || w_div_ovf;
        w_fast_res = '0;
        if (w_div_zero) begin
            w_fast_res = r_op[1] ? r_a : '1;
        end else if (w_div_ovf) begin
            w_fast_res = r_op[1] ? '0 : MIN_NEG;
        end
`ifdef MDU_EARLY_OUT_EN
        else if (!w_is_div && ((w_a_abs == '0) || (w_b_abs == '0))) begin
            w_fast     = 1'b1;
            w_fast_res = '0;
        end else if (!w_is_div && ((w_a_abs == XLEN'(1)) || (w_b_abs == XLEN'(1)))) begin
            w_fast     = 1'b1;
            w_fast_res = w_fin;
        end
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (mdu.start && !mdu.flush) w_next = S_PREP;
            S_PREP:  w_next = w_fast ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == STEP_CNT_W'(XLEN-1)) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (mdu.flush && (r_state != S_IDLE)) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (mdu.start && !mdu.flush) begin
                        r_a  <= mdu.ReadData1;
                        r_b  <= mdu.ReadData2;
                        r_op <= mdu.funct3;
                    end
                end
                S_PREP: begin
                    r_hi  <= '0;
                    r_lo  <= w_a_abs;
                    r_b   <= w_b_abs;
                    r_neg <= w_res_neg;
                    r_cnt <= '0;
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_is_div) begin
                        r_hi <= w_sum[XLEN:1];
                        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                    end else if (!w_trial[XLEN]) begin
                        r_hi <= w_trial[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], 1'b1};
                    end else begin
                        r_hi <= {r_hi[XLEN-2:0], r_lo[XLEN-1]};
                        r_lo <= {r_lo[XLEN-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
            // Result only moves on entry to DONE, so a flushed operation leaves it untouched.
            if (w_next == S_DONE) begin
                r_result <= (r_state == S_PREP) ? w_fast_res : w_fin;
            end
        end
    end

    assign mdu.MDUResult = r_result;
    assign mdu.done      = (r_state == S_DONE);
    assign mdu.busy      = (r_state != S_IDLE);
    assign mdu.stall     = (mdu.start && (r_state == S_IDLE)) ||
                           ((r_state != S_IDLE) && (r_state != S_DONE));
    assign o_state       = r_state;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer; honours MDU_EARLY_OUT_EN for multiply latency.
module tb_mdu_sequencer;
    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;
    int         n_tests;
    int         n_fail;
    int         lat;
    logic [31:0] saved;

    mdu_sequencer_if #(.XLEN(32)) bus ();

    mdu_sequencer #(.XLEN(32), .STEP_CNT_W(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mdu     (bus.slave),
        .o_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MDU_EARLY_OUT_EN
    localparam int MUL_TRIVIAL_LAT = 2;
`else
    localparam int MUL_TRIVIAL_LAT = 35;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, count cycles to done (bounded), check latency, result and idle return.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        bit stall_ok;
        @(negedge clk);
        bus.funct3 = f; bus.ReadData1 = a; bus.ReadData2 = b; bus.start = 1'b1;
        #1 check({tag, "_stall_req"}, {31'b0, bus.stall}, 32'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.ReadData1 = $urandom; bus.ReadData2 = $urandom; bus.funct3 = 3'($urandom_range(0, 7));
        lat = 1;
        stall_ok = 1'b1;
        while (!bus.done && lat < 60) begin
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_done"}, {31'b0, bus.done}, 32'd1);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, bus.MDUResult, exp);
        check({tag, "_stall_busy"}, {31'b0, stall_ok}, 32'd1);
        check({tag, "_stall_done"}, {31'b0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
        check({tag, "_idle"}, {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'b0;
        bus.ReadData1 = '0; bus.ReadData2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", bus.MDUResult, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_stall", {31'b0, bus.stall}, 32'd0);
        check("rst_state", {29'b0, dbg_state}, 32'd0);
        rst_n = 1'b1;

        run_op("mul_7x6",     3'b000, 32'd7,        32'd6,        32'd42,       35);
        run_op("mulh_m1m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 35);
        run_op("mulhu_m1m1",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35);
        run_op("mulhsu_m1x2", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 35);
        run_op("mulhu_big",   3'b011, 32'h80000000, 32'd4,        32'h00000002, 35);
        run_op("div_m7_2",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35);
        run_op("rem_m7_2",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35);
        run_op("div_7_m2",    3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 35);
        run_op("rem_7_m2",    3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 35);
        run_op("divu_5_0",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 2);
        run_op("remu_5_0",    3'b111, 32'd5,        32'd0,        32'h00000005, 2);
        run_op("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
        run_op("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2);
        run_op("mul_0x1234",  3'b000, 32'd0,        32'd1234,     32'd0,        MUL_TRIVIAL_LAT);
        run_op("mul_x1",      3'b000, 32'd12345,    32'd1,        32'd12345,    MUL_TRIVIAL_LAT);
        run_op("mulh_m5x1",   3'b001, 32'hFFFFFFFB, 32'd1,        32'hFFFFFFFF, MUL_TRIVIAL_LAT);
        run_op("divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14,       35);

        // Flush a DIVU in cycle T+10: idle at T+11, no done, result kept.
        saved = bus.MDUResult;
        check("flush_saved", saved, 32'd14);
        @(negedge clk);
        bus.funct3 = 3'b101; bus.ReadData1 = 32'd1000; bus.ReadData2 = 32'd3; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk);
            #1;
        end
        check("flush_busy_T10", {31'b0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        check("flush_idle", {31'b0, bus.busy}, 32'd0);
        check("flush_state", {29'b0, dbg_state}, 32'd0);
        check("flush_done", {31'b0, bus.done}, 32'd0);
        check("flush_result", bus.MDUResult, saved);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                check("flush_quiet", {30'b0, bus.busy, bus.done}, 32'd0);
                break;
            end
        end

        // flush and start together in IDLE: request dropped.
        @(negedge clk);
        bus.funct3 = 3'b000; bus.ReadData1 = 32'd3; bus.ReadData2 = 32'd3;
        bus.start = 1'b1; bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_start_idle", {31'b0, bus.busy}, 32'd0);

        // start held through the whole operation, including the DONE cycle: no retrigger.
        @(negedge clk);
        bus.funct3 = 3'b000; bus.ReadData1 = 32'd3; bus.ReadData2 = 32'd5; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.ReadData1 = 32'd99; bus.ReadData2 = 32'd77;
        lat = 1;
        while (!bus.done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("hold_lat", lat, 35);
        check("hold_res", bus.MDUResult, 32'd15);
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("hold_no_retrigger", {31'b0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        check("hold_still_idle", {31'b0, bus.busy}, 32'd0);

        // Reset in cycle T+20 of a multiply.
        @(negedge clk);
        bus.funct3 = 3'b000; bus.ReadData1 = 32'd9; bus.ReadData2 = 32'd9; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 1; k < 20; k++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("midrst_result", bus.MDUResult, 32'd0);
        check("midrst_done", {31'b0, bus.done}, 32'd0);
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_stall", {31'b0, bus.stall}, 32'd0);
        run_op("after_rst", 3'b000, 32'd7, 32'd6, 32'd42, 35);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
